// File: rtl/plot_framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : plot_framebuffer_writer
// Purpose  : Receives xpos/ypos/plot pixel requests, queues them in a small
//            FIFO, range-checks them and writes one pixel per cycle into a
//            160x120 framebuffer port. After reset, or on a clear pulse, it
//            sweeps the whole framebuffer to the background colour.
// Revision : 1.0  initial release
// ============================================================================
module plot_framebuffer_writer #(
  parameter int unsigned X_MAX      = 160,
  parameter int unsigned Y_MAX      = 120,
  parameter int unsigned FIFO_DEPTH = 4,      // power of two, at least 2
  parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  xpos,
  input  logic [6:0]  ypos,
  input  logic [2:0]  colour,
  input  logic        plot,
  input  logic        clear,
  output logic        busy,
  output logic        fifo_full,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  output logic [7:0]  drop_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned c_ptr_w     = $clog2(FIFO_DEPTH);
  localparam int unsigned c_cnt_w     = c_ptr_w + 1;
  localparam int unsigned c_entry_w   = 18;   // {x[7:0], y[6:0], colour[2:0]}
  localparam int unsigned c_pixels    = X_MAX * Y_MAX;
  localparam int unsigned c_pixels_m1 = c_pixels - 1;

  localparam logic [7:0]         c_x_max      = X_MAX[7:0];
  localparam logic [6:0]         c_y_max      = Y_MAX[6:0];
  localparam logic [14:0]        c_sweep_last = c_pixels_m1[14:0];
  localparam logic [c_cnt_w-1:0] c_depth      = FIFO_DEPTH[c_cnt_w-1:0];
  localparam logic [c_cnt_w-1:0] c_cnt_one    = {{(c_cnt_w-1){1'b0}}, 1'b1};
  localparam logic [c_ptr_w-1:0] c_ptr_one    = {{(c_ptr_w-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                 state_q;
  logic [14:0]            sweep_q;
  logic                   busy_q;
  logic                   mem_we_q;
  logic [14:0]            mem_addr_q;
  logic [2:0]             mem_data_q;
  logic [7:0]             drop_q;
  logic                   full_q;

  logic [c_entry_w-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0]     wr_ptr_q;
  logic [c_ptr_w-1:0]     rd_ptr_q;
  logic [c_cnt_w-1:0]     count_q;
  logic [c_cnt_w-1:0]     count_d;

  // --------------------------------------------------------------------------
  // Combinational request qualification
  // --------------------------------------------------------------------------
  logic                   in_range;
  logic                   fifo_is_full;
  logic                   fifo_is_empty;
  logic                   push;
  logic                   drop;
  logic                   pop;
  logic [c_entry_w-1:0]   head;
  logic [7:0]             head_x;
  logic [6:0]             head_y;
  logic [2:0]             head_c;
  logic [14:0]            head_addr;

  assign in_range      = (xpos < c_x_max) && (ypos < c_y_max);
  // Fullness is taken from the registered count, i.e. before this cycle's pop,
  // so a full queue refuses a push even if it is being drained this cycle.
  assign fifo_is_full  = (count_q == c_depth);
  assign fifo_is_empty = (count_q == '0);
  assign push          = plot && in_range && !fifo_is_full;
  assign drop          = plot && !(in_range && !fifo_is_full);
  // A clear pulse freezes the queue so pending pixels land after the sweep.
  assign pop           = (state_q == ST_DRAIN) && !clear && !fifo_is_empty;

  assign head   = fifo_mem_q[rd_ptr_q];
  assign head_x = head[17:10];
  assign head_y = head[9:3];
  assign head_c = head[2:0];
  // y*160 + x built from shifts: y*128 + y*32 + x.
  assign head_addr = {1'b0, head_y, 7'b0} + {3'b0, head_y, 5'b0} + {7'b0, head_x};

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Queue storage: data only, validity is tracked by the pointers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {xpos, ypos, colour};
    end
  end

  // Queue pointers, occupancy and registered full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + c_ptr_one;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + c_ptr_one;
      end
      count_q <= count_d;
      full_q  <= (count_d == c_depth);
    end
  end

  // Saturating count of rejected requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= 8'd0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  // Clear/drain sequencer driving the registered framebuffer port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      sweep_q    <= 15'd0;
      busy_q     <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 15'd0;
      mem_data_q <= 3'b000;
    end else if (clear) begin
      // Restart the sweep from the top-left pixel; nothing is written this cycle.
      state_q    <= ST_CLEAR;
      sweep_q    <= 15'd0;
      busy_q     <= 1'b1;
      mem_we_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          busy_q     <= 1'b1;
          mem_we_q   <= 1'b1;
          mem_addr_q <= sweep_q;
          mem_data_q <= BG_COLOUR;
          if (sweep_q == c_sweep_last) begin
            state_q <= ST_DRAIN;
            sweep_q <= 15'd0;
          end else begin
            sweep_q <= sweep_q + 15'd1;
          end
        end
        ST_DRAIN: begin
          // busy drops one cycle after the final background write.
          busy_q <= 1'b0;
          if (pop) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= head_addr;
            mem_data_q <= head_c;
          end else begin
            mem_we_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_CLEAR;
          sweep_q  <= 15'd0;
          busy_q   <= 1'b1;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy       = busy_q;
  assign fifo_full  = full_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign drop_count = drop_q;

endmodule
`default_nettype wire
